xintf_dpbram_bridge: RTL
========================

# xintf_dpbram_bridge

DSP-side responder for the Zynq/DSP dual-port BRAM mailbox pair. It lets the DSP reach both RAMs through its asynchronous XINTF external-memory bus. DSP reads are served from the read port of the Zynq-to-DSP RAM. DSP writes are committed into the write port of the DSP-to-Zynq RAM. It sits in the 200 MHz fabric domain beside the core top and drives the DSP data pins through an output enable.

## Interface
Parameters:
- ADDR_WIDTH, 9, XINTF/BRAM address width
- DATA_WIDTH, 16, XINTF/BRAM data width
- RD_DEPTH, 43, valid words in Zynq-to-DSP RAM
- WR_DEPTH, 10, valid words in DSP-to-Zynq RAM

Ports:
- i_clk  in  1  fabric clock, 200 MHz
- i_rst  in  1  reset; asynchronous, active-high
- i_xintf_cs_n  in  1  DSP zone chip select, asynchronous
- i_xintf_rd_n  in  1  DSP read strobe, asynchronous
- i_xintf_we_n  in  1  DSP write strobe, asynchronous
- i_xintf_addr  in  ADDR_WIDTH  DSP address
- i_xintf_data  in  DATA_WIDTH  data pins, input path
- o_xintf_data  out  DATA_WIDTH  data pins, output path
- o_xintf_data_oe  out  1  pad output enable, 1 = drive
- o_dsp_z_to_d_addr  out  ADDR_WIDTH  Zynq-to-DSP RAM read address
- o_dsp_z_to_d_ce  out  1  read enable
- o_dsp_z_to_d_we  out  1  tied 0
- i_dsp_z_to_d_dout  in  DATA_WIDTH  read data, 1-cycle RAM latency
- o_dsp_d_to_z_addr  out  ADDR_WIDTH  DSP-to-Zynq RAM write address
- o_dsp_d_to_z_ce  out  1  write strobe qualifier
- o_dsp_d_to_z_we  out  1  write enable
- o_dsp_d_to_z_din  out  DATA_WIDTH  write data
- i_err_clr  in  1  clears sticky errors, synchronous pulse
- o_bus_err  out  1  sticky: rd_n and we_n low together
- o_addr_err  out  1  sticky: out-of-range access
- o_rd_cnt  out  16  completed reads, wraps
- o_wr_cnt  out  16  completed writes, wraps

## Operation
Input synchronisation:
- cs_n, rd_n, we_n, addr and data pass through an identical 2-flop pipeline, so all pipelined samples stay aligned.
- Decoding uses stage-2 values only.

FSM states:
- IDLE:
  - On synchronised cs_n=0 with an rd_n falling edge: go to RD_ISSUE.
  - On synchronised cs_n=0 with we_n=0: go to WR_ACTIVE.
- RD_ISSUE (1 cycle):
  - In range (addr < RD_DEPTH): ce=1 and addr driven.
  - Out of range: ce=0, o_addr_err set, data forced to 0x0000.
  - Next state: RD_WAIT.
- RD_WAIT (1 cycle): dout registered into o_xintf_data. Next state: RD_HOLD.
- RD_HOLD:
  - o_xintf_data_oe=1 and data held.
  - Exit to IDLE when synchronised rd_n=1 or cs_n=1, with oe=0 on the exit cycle.
  - o_rd_cnt increments on exit.
- WR_ACTIVE:
  - Each cycle, the stage-2 addr/data is latched while we_n=0.
  - On synchronised we_n rising edge (or cs_n rising): go to WR_COMMIT.
- WR_COMMIT (1 cycle):
  - Commits the last latched addr/data from the last low sample.
  - In range (addr < WR_DEPTH): ce=we=1 for exactly one cycle, o_wr_cnt increments.
  - Out of range: no RAM write, o_addr_err set, o_wr_cnt still increments.
  - Next state: IDLE.

Boundary conditions:
- rd_n=0 and we_n=0 together (synchronised) in any state:
  - o_bus_err set, oe=0, no RAM access, go to IDLE.
  - A new access is accepted only after both strobes return high.
- Back-to-back reads with cs_n held low: each rd_n falling edge is a new access.
- i_err_clr and a new error on the same cycle: the error wins (flag stays 1).
- Counters wrap 0xFFFF to 0x0000.
- Reset asserted mid-access:
  - oe drops asynchronously.
  - Any pending write is discarded.
  - State returns to IDLE.

## Timing
- Reset value of every output is 0, including oe, data, counters, flags and all RAM controls.
- Read path, counting from the rd_n falling edge at the pin:
  - cycle 2: sync complete
  - cycle 3: RAM ce/addr
  - cycle 4: dout
  - cycle 5: o_xintf_data valid with oe=1
- The DSP read strobe must be ≥ 7 cycles (35 ns); DSP wait states are configured accordingly.
- oe deasserts ≤ 3 cycles after rd_n or cs_n rises.
- Write path: RAM write occurs 3 cycles after the we_n rising edge at the pin. DSP write strobe must be ≥ 3 cycles.
- The DSP must hold addr/data stable for the whole strobe.

## Configuration
- XINTF_ACCESS_CNT_EN defined: o_rd_cnt and o_wr_cnt are implemented as specified.
- XINTF_ACCESS_CNT_EN undefined: counters are removed and both outputs are tied to 0. All other behaviour is identical.

## Test plan
- Read: RAM word 5 = 0xA5C3, DSP read addr 5 with 8-cycle strobe → oe=1 from cycle 5, o_xintf_data=0xA5C3, o_rd_cnt=1, oe=0 ≤3 cycles after rd_n rises.
- Write: DSP writes 0x1234 to addr 3, 4-cycle strobe → single ce=we=1 pulse with addr=3, din=0x1234, 3 cycles after we_n rises; o_wr_cnt=1.
- Range: read addr 43 → data 0x0000, ce never 1, o_addr_err=1. Write addr 10 → no we pulse, o_addr_err=1. i_err_clr → flag 0.
- Collision: rd_n and we_n low together for 6 cycles → o_bus_err=1, no RAM access, oe stays 0.
- Reset mid-read: assert i_rst during RD_HOLD → oe=0 immediately. After release, the next read to addr 0 completes normally.
- Macro: build without XINTF_ACCESS_CNT_EN, 10 reads/10 writes → o_rd_cnt=o_wr_cnt=0, data paths unchanged.

Source files
------------

// File: rtl/xintf_dpbram_bridge.sv
// XINTF responder bridging DSP bus cycles onto the Zynq/DSP dual-port BRAM mailbox pair.
// Define XINTF_ACCESS_CNT_EN to build the completed-access counters; otherwise they read as 0.
module xintf_dpbram_bridge #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 16,
    parameter int RD_DEPTH   = 43,
    parameter int WR_DEPTH   = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_xintf_cs_n,
    input  logic                  i_xintf_rd_n,
    input  logic                  i_xintf_we_n,
    input  logic [ADDR_WIDTH-1:0] i_xintf_addr,
    input  logic [DATA_WIDTH-1:0] i_xintf_data,
    output logic [DATA_WIDTH-1:0] o_xintf_data,
    output logic                  o_xintf_data_oe,
    output logic [ADDR_WIDTH-1:0] o_dsp_z_to_d_addr,
    output logic                  o_dsp_z_to_d_ce,
    output logic                  o_dsp_z_to_d_we,
    input  logic [DATA_WIDTH-1:0] i_dsp_z_to_d_dout,
    output logic [ADDR_WIDTH-1:0] o_dsp_d_to_z_addr,
    output logic                  o_dsp_d_to_z_ce,
    output logic                  o_dsp_d_to_z_we,
    output logic [DATA_WIDTH-1:0] o_dsp_d_to_z_din,
    input  logic                  i_err_clr,
    output logic                  o_bus_err,
    output logic                  o_addr_err,
    output logic [15:0]           o_rd_cnt,
    output logic [15:0]           o_wr_cnt,
    output logic [2:0]            o_dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_ISSUE  = 3'd1,
        ST_RD_WAIT   = 3'd2,
        ST_RD_HOLD   = 3'd3,
        ST_WR_ACTIVE = 3'd4,
        ST_WR_COMMIT = 3'd5
    } state_e;

    localparam logic [ADDR_WIDTH:0] RD_LIMIT = (ADDR_WIDTH+1)'(RD_DEPTH);
    localparam logic [ADDR_WIDTH:0] WR_LIMIT = (ADDR_WIDTH+1)'(WR_DEPTH);

    logic                  cs_s1_q, cs_s2_q;
    logic                  rd_s1_q, rd_s2_q, rd_s3_q;
    logic                  we_s1_q, we_s2_q;
    logic [ADDR_WIDTH-1:0] addr_s1_q, addr_s2_q;
    logic [DATA_WIDTH-1:0] data_s1_q, data_s2_q;

    state_e                state_q, state_d;
    logic                  blocked_q, blocked_d;
    logic                  rd_oor_q, rd_oor_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0] wlat_addr_q, wlat_addr_d;
    logic [DATA_WIDTH-1:0] wlat_data_q, wlat_data_d;
    logic                  bus_err_q, bus_err_d;
    logic                  addr_err_q, addr_err_d;
    logic                  rd_done, wr_done;

    logic collision, rd_fall, rd_in_range, wr_in_range;

    // Strobes reset to their inactive level so reset release never looks like an edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            rd_s1_q   <= 1'b1;
            rd_s2_q   <= 1'b1;
            rd_s3_q   <= 1'b1;
            we_s1_q   <= 1'b1;
            we_s2_q   <= 1'b1;
            addr_s1_q <= '0;
            addr_s2_q <= '0;
            data_s1_q <= '0;
            data_s2_q <= '0;
        end else begin
            cs_s1_q   <= i_xintf_cs_n;
            cs_s2_q   <= cs_s1_q;
            rd_s1_q   <= i_xintf_rd_n;
            rd_s2_q   <= rd_s1_q;
            rd_s3_q   <= rd_s2_q;
            we_s1_q   <= i_xintf_we_n;
            we_s2_q   <= we_s1_q;
            addr_s1_q <= i_xintf_addr;
            addr_s2_q <= addr_s1_q;
            data_s1_q <= i_xintf_data;
            data_s2_q <= data_s1_q;
        end
    end

    assign collision   = !rd_s2_q && !we_s2_q;
    assign rd_fall     = rd_s3_q && !rd_s2_q;
    assign rd_in_range = {1'b0, addr_s2_q} < RD_LIMIT;
    assign wr_in_range = {1'b0, wlat_addr_q} < WR_LIMIT;

    always_comb begin
        state_d           = state_q;
        blocked_d         = blocked_q;
        rd_oor_d          = rd_oor_q;
        rdata_d           = rdata_q;
        wlat_addr_d       = wlat_addr_q;
        wlat_data_d       = wlat_data_q;
        bus_err_d         = bus_err_q && !i_err_clr;
        addr_err_d        = addr_err_q && !i_err_clr;
        rd_done           = 1'b0;
        wr_done           = 1'b0;
        o_xintf_data_oe   = 1'b0;
        o_dsp_z_to_d_ce   = 1'b0;
        o_dsp_z_to_d_addr = '0;
        o_dsp_d_to_z_ce   = 1'b0;
        o_dsp_d_to_z_we   = 1'b0;
        o_dsp_d_to_z_addr = '0;
        o_dsp_d_to_z_din  = '0;

        if (rd_s2_q && we_s2_q) begin
            blocked_d = 1'b0;
        end

        // A collision aborts whatever is in flight and locks out new accesses until both strobes rise.
        if (collision) begin
            bus_err_d = 1'b1;
            blocked_d = 1'b1;
            state_d   = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!blocked_q && !cs_s2_q) begin
                        if (rd_fall) begin
                            state_d = ST_RD_ISSUE;
                        end else if (!we_s2_q) begin
                            state_d     = ST_WR_ACTIVE;
                            wlat_addr_d = addr_s2_q;
                            wlat_data_d = data_s2_q;
                        end
                    end
                end
                ST_RD_ISSUE: begin
                    if (rd_in_range) begin
                        o_dsp_z_to_d_ce   = 1'b1;
                        o_dsp_z_to_d_addr = addr_s2_q;
                        rd_oor_d          = 1'b0;
                    end else begin
                        rd_oor_d   = 1'b1;
                        addr_err_d = 1'b1;
                    end
                    state_d = ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    rdata_d = rd_oor_q ? '0 : i_dsp_z_to_d_dout;
                    state_d = ST_RD_HOLD;
                end
                ST_RD_HOLD: begin
                    if (rd_s2_q || cs_s2_q) begin
                        rd_done = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        o_xintf_data_oe = 1'b1;
                    end
                end
                ST_WR_ACTIVE: begin
                    if (!we_s2_q && !cs_s2_q) begin
                        wlat_addr_d = addr_s2_q;
                        wlat_data_d = data_s2_q;
                    end else begin
                        state_d = ST_WR_COMMIT;
                    end
                end
                ST_WR_COMMIT: begin
                    if (wr_in_range) begin
                        o_dsp_d_to_z_ce   = 1'b1;
                        o_dsp_d_to_z_we   = 1'b1;
                        o_dsp_d_to_z_addr = wlat_addr_q;
                        o_dsp_d_to_z_din  = wlat_data_q;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                    wr_done = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            blocked_q   <= 1'b0;
            rd_oor_q    <= 1'b0;
            rdata_q     <= '0;
            wlat_addr_q <= '0;
            wlat_data_q <= '0;
            bus_err_q   <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            blocked_q   <= blocked_d;
            rd_oor_q    <= rd_oor_d;
            rdata_q     <= rdata_d;
            wlat_addr_q <= wlat_addr_d;
            wlat_data_q <= wlat_data_d;
            bus_err_q   <= bus_err_d;
            addr_err_q  <= addr_err_d;
        end
    end

`ifdef XINTF_ACCESS_CNT_EN
    logic [15:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_q + {15'd0, rd_done};
            wr_cnt_q <= wr_cnt_q + {15'd0, wr_done};
        end
    end

    assign o_rd_cnt = rd_cnt_q;
    assign o_wr_cnt = wr_cnt_q;
`else
    logic cnt_unused;
    assign cnt_unused = rd_done | wr_done;
    assign o_rd_cnt   = '0;
    assign o_wr_cnt   = '0;
`endif

    assign o_xintf_data    = rdata_q;
    assign o_dsp_z_to_d_we = 1'b0;
    assign o_bus_err       = bus_err_q;
    assign o_addr_err      = addr_err_q;
    assign o_dbg_state     = state_q;

endmodule
